// File: rtl/memory_arbiter_pkg.sv
// memory_arbiter_pkg: shared FSM states, command encodings and round-robin search helper.
package memory_arbiter_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

    localparam logic MEMORY_READ  = 1'b0;
    localparam logic MEMORY_WRITE = 1'b1;

    // First asserted channel at or above pointer, wrapping modulo channels (up to 8).
    function automatic logic [2:0] next_channel(input logic [2:0] pointer, input logic [7:0] enable, input int channels);
        logic [2:0] pick;
        logic found;
        int idx;
        pick = pointer;
        found = 1'b0;
        for (int i = 0; i < 8; i++) begin
            idx = (int'(pointer) + i) % channels;
            if (!found && i < channels && enable[idx[2:0]]) begin
                pick = idx[2:0];
                found = 1'b1;
            end
        end
        return pick;
    endfunction

endpackage

// File: rtl/memory_arbiter_round_robin_select.sv
// round_robin_select: combinational grant index and any-request flag from the enable vector and pointer.
module round_robin_select
    import memory_arbiter_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int IW = 1
) (
    input  logic [CHANNELS-1:0] enable,
    input  logic [IW-1:0]       pointer,
    output logic [IW-1:0]       grant,
    output logic                any
);

    always_comb begin
        grant = IW'(next_channel(3'(pointer), 8'(enable), CHANNELS));
        any = |enable;
    end

endmodule

// File: rtl/memory_arbiter.sv
// memory_arbiter: round-robin N-master arbiter onto one memory port, one transaction in flight.
// Optional WAIT-state timeout with req_error output is enabled by MEMORY_ARBITER_TIMEOUT_EN.
module memory_arbiter
    import memory_arbiter_pkg::*;
#(
    parameter int CHANNELS = 2,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic [CHANNELS-1:0]      req_enable,
    input  logic [CHANNELS-1:0]      req_command,
    input  logic [32*CHANNELS-1:0]   req_read_address,
    input  logic [32*CHANNELS-1:0]   req_write_address,
    input  logic [32*CHANNELS-1:0]   req_write_data,
    input  logic [32*CHANNELS-1:0]   req_write_mask,
    output logic [CHANNELS-1:0]      req_ready,
    output logic [CHANNELS-1:0]      req_valid,
    output logic [31:0]              req_read_data,
    input  logic                     memory_ready,
    input  logic                     memory_valid,
    input  logic [31:0]              read_memory_data,
    output logic [31:0]              read_memory_address,
    output logic [31:0]              write_memory_address,
    output logic [31:0]              write_memory_data,
    output logic [31:0]              write_memory_mask,
    output logic                     memory_command,
    output logic                     memory_enable
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    ,
    output logic                     req_error
`endif
);

    localparam int IW = CHANNELS > 1 ? $clog2(CHANNELS) : 1;

    state_t state, state_next;
    logic [IW-1:0] pointer, pointer_next, grant, sel;
    logic any, complete, timeout, command;
    logic [31:0] read_address, write_address, write_data, write_mask, read_data;
    logic [CHANNELS-1:0] onehot, valid;

    round_robin_select #(.CHANNELS(CHANNELS), .IW(IW)) u_select (
        .enable (req_enable),
        .pointer(pointer),
        .grant  (sel),
        .any    (any)
    );

`ifdef MEMORY_ARBITER_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] count;
    logic error;
    always_ff @(posedge clk) begin
        if (reset) begin
            count <= '0;
            error <= 1'b0;
        end else begin
            count <= (state == WAIT) ? count + TW'(1) : '0;
            error <= timeout;
        end
    end
    assign timeout = state == WAIT && !memory_valid && count == TW'(TIMEOUT_CYCLES - 1);
    assign req_error = error;
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_next = state;
        complete = 1'b0;
        case (state)
            IDLE: state_next = any ? ISSUE : IDLE;
            ISSUE: begin
                complete = memory_ready && memory_valid;
                state_next = memory_ready ? (memory_valid ? IDLE : WAIT) : ISSUE;
            end
            WAIT: begin
                complete = memory_valid;
                state_next = (memory_valid || timeout) ? IDLE : WAIT;
            end
            default: state_next = IDLE;
        endcase
    end

    assign onehot = CHANNELS'(1) << grant;
    assign pointer_next = (int'(grant) == CHANNELS - 1) ? '0 : grant + IW'(1);
    assign memory_enable = state == ISSUE;
    assign req_ready = (state == ISSUE && memory_ready) ? onehot : '0;
    assign req_valid = valid;
    assign req_read_data = read_data;
    assign memory_command = command == MEMORY_WRITE;
    assign read_memory_address = read_address;
    assign write_memory_address = write_address;
    assign write_memory_data = write_data;
    assign write_memory_mask = write_mask;

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            pointer <= '0;
            grant <= '0;
            command <= MEMORY_READ;
            read_address <= '0;
            write_address <= '0;
            write_data <= '0;
            write_mask <= '0;
            valid <= '0;
            read_data <= '0;
        end else begin
            state <= state_next;
            valid <= (complete || timeout) ? onehot : '0;
            if (state == IDLE && any) begin
                grant <= sel;
                command <= req_command[sel];
                read_address <= req_read_address[32*int'(sel) +: 32];
                write_address <= req_write_address[32*int'(sel) +: 32];
                write_data <= req_write_data[32*int'(sel) +: 32];
                write_mask <= req_write_mask[32*int'(sel) +: 32];
            end
            // Timeout completions report zero data rather than whatever is on the bus.
            if (complete || timeout) begin
                pointer <= pointer_next;
                read_data <= complete ? read_memory_data : '0;
            end
        end
    end

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed scoreboard bench for a 3-channel memory_arbiter.
module tb_memory_arbiter;
    import memory_arbiter_pkg::*;

    localparam int CH = 3;

    logic clk = 1'b0;
    logic reset;
    logic [CH-1:0] req_enable, req_command, req_ready, req_valid;
    logic [32*CH-1:0] req_read_address, req_write_address, req_write_data, req_write_mask;
    logic [31:0] req_read_data, read_memory_data;
    logic memory_ready, memory_valid, memory_command, memory_enable;
    logic [31:0] read_memory_address, write_memory_address, write_memory_data, write_memory_mask;
`ifdef MEMORY_ARBITER_TIMEOUT_EN
    logic req_error;
`endif

    int n_checks = 0;
    int n_fail = 0;
    logic [CH-1:0] exp_ready_q[$];
    logic [CH-1:0] exp_valid_q[$];
    logic [31:0] exp_data_q[$];

    always #5 clk = ~clk;

    memory_arbiter #(.CHANNELS(CH), .TIMEOUT_CYCLES(8)) dut (
        .clk(clk),
        .reset(reset),
        .req_enable(req_enable),
        .req_command(req_command),
        .req_read_address(req_read_address),
        .req_write_address(req_write_address),
        .req_write_data(req_write_data),
        .req_write_mask(req_write_mask),
        .req_ready(req_ready),
        .req_valid(req_valid),
        .req_read_data(req_read_data),
        .memory_ready(memory_ready),
        .memory_valid(memory_valid),
        .read_memory_data(read_memory_data),
        .read_memory_address(read_memory_address),
        .write_memory_address(write_memory_address),
        .write_memory_data(write_memory_data),
        .write_memory_mask(write_memory_mask),
        .memory_command(memory_command),
        .memory_enable(memory_enable)
`ifdef MEMORY_ARBITER_TIMEOUT_EN
        ,
        .req_error(req_error)
`endif
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #2;
    endtask

    // Scoreboard: every completion and acceptance the DUT produces is matched against the queues.
    always @(negedge clk) begin
        if (req_ready != '0)
            check("ready_grant", 32'(req_ready), exp_ready_q.size() != 0 ? 32'(exp_ready_q.pop_front()) : 32'd0);
        if (req_valid != '0) begin
            check("valid_chan", 32'(req_valid), exp_valid_q.size() != 0 ? 32'(exp_valid_q.pop_front()) : 32'd0);
            check("valid_data", req_read_data, exp_data_q.size() != 0 ? exp_data_q.pop_front() : 32'hDEAD_BEEF);
        end
    end

    task automatic expect_txn(input int ch, input logic [31:0] data);
        exp_ready_q.push_back(CH'(1) << ch);
        exp_valid_q.push_back(CH'(1) << ch);
        exp_data_q.push_back(data);
    endtask

    task automatic wait_enable(output int cycles);
        cycles = 0;
        while (memory_enable !== 1'b1 && cycles < 20) begin
            tick;
            cycles++;
        end
        check("issue_reached", 32'(memory_enable), 32'd1);
    endtask

    // Accept in the ISSUE cycle; memory_valid follows lat cycles later (0 = same cycle).
    task automatic accept(input logic [31:0] data, input int lat);
        memory_ready = 1'b1;
        if (lat == 0) begin
            memory_valid = 1'b1;
            read_memory_data = data;
        end
        tick;
        memory_ready = 1'b0;
        memory_valid = 1'b0;
        if (lat > 0) begin
            check("wait_enable_low", 32'(memory_enable), 32'd0);
            repeat (lat - 1) tick;
            memory_valid = 1'b1;
            read_memory_data = data;
            tick;
            memory_valid = 1'b0;
        end
    endtask

    task automatic set_chan(input int ch, input logic cmd, input logic [31:0] ra, input logic [31:0] wa,
                            input logic [31:0] wd, input logic [31:0] wm);
        req_command[ch] = cmd;
        req_read_address[32*ch +: 32] = ra;
        req_write_address[32*ch +: 32] = wa;
        req_write_data[32*ch +: 32] = wd;
        req_write_mask[32*ch +: 32] = wm;
    endtask

    task automatic txn(input int ch, input logic cmd, input logic [31:0] ra, input logic [31:0] wa,
                       input logic [31:0] wd, input logic [31:0] wm, input logic [31:0] rd, input int lat,
                       output int cycles);
        set_chan(ch, cmd, ra, wa, wd, wm);
        req_enable[ch] = 1'b1;
        expect_txn(ch, rd);
        wait_enable(cycles);
        check("fwd_read_addr", read_memory_address, ra);
        check("fwd_write_addr", write_memory_address, wa);
        check("fwd_write_data", write_memory_data, wd);
        check("fwd_write_mask", write_memory_mask, wm);
        check("fwd_command", 32'(memory_command), 32'(cmd));
        accept(rd, lat);
        req_enable[ch] = 1'b0;
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_state"}, 32'(dut.state), 32'(IDLE));
        check({tag, "_enable"}, 32'(memory_enable), 32'd0);
        check({tag, "_ready"}, 32'(req_ready), 32'd0);
        check({tag, "_valid"}, 32'(req_valid), 32'd0);
        check({tag, "_rdata"}, req_read_data, 32'd0);
        check({tag, "_raddr"}, read_memory_address, 32'd0);
        check({tag, "_waddr"}, write_memory_address, 32'd0);
        check({tag, "_wdata"}, write_memory_data, 32'd0);
        check({tag, "_wmask"}, write_memory_mask, 32'd0);
        check({tag, "_cmd"}, 32'(memory_command), 32'd0);
    endtask

    initial begin
        int c;
        reset = 1'b1;
        req_enable = '0;
        req_command = '0;
        req_read_address = '0;
        req_write_address = '0;
        req_write_data = '0;
        req_write_mask = '0;
        memory_ready = 1'b0;
        memory_valid = 1'b0;
        read_memory_data = '0;
        tick;
        tick;
        check_idle_outputs("reset");
        reset = 1'b0;
        tick;

        // Round-robin with all channels requesting continuously.
        for (int i = 0; i < CH; i++) set_chan(i, MEMORY_READ, 32'h1000 + 32'(4 * i), 32'h0, 32'h0, 32'h0);
        req_enable = '1;
        for (int k = 0; k < 6; k++) begin
            expect_txn(k % CH, 32'hA0 + 32'(k));
            wait_enable(c);
            check("rr_addr", read_memory_address, 32'h1000 + 32'(4 * (k % CH)));
            accept(32'hA0 + 32'(k), 1);
        end
        req_enable = '0;
        tick;

        // Single read, channel 1, completion two cycles after acceptance.
        txn(1, MEMORY_READ, 32'h100, 32'h0, 32'h0, 32'h0, 32'hCAFE_F00D, 2, c);
        check("read_latency", 32'(c), 32'd1);
        tick;

        // Write forwarding on channel 0.
        txn(0, MEMORY_WRITE, 32'h0, 32'h20, 32'h1234_5678, 32'h0000_FFFF, 32'h7777_0000, 1, c);
        tick;

        // Simultaneous memory_ready and memory_valid in ISSUE.
        set_chan(1, MEMORY_READ, 32'h200, 32'h0, 32'h0, 32'h0);
        req_enable[1] = 1'b1;
        expect_txn(1, 32'h5A5A_0001);
        wait_enable(c);
        memory_ready = 1'b1;
        memory_valid = 1'b1;
        read_memory_data = 32'h5A5A_0001;
        #1;
        check("simul_ready", 32'(req_ready), 32'b010);
        tick;
        memory_ready = 1'b0;
        memory_valid = 1'b0;
        req_enable[1] = 1'b0;
        check("simul_valid", 32'(req_valid), 32'b010);
        check("simul_state", 32'(dut.state), 32'(IDLE));
        tick;
        check("simul_idle2", 32'(dut.state), 32'(IDLE));
        check("simul_valid_gone", 32'(req_valid), 32'd0);

        // Reset during WAIT drops the transaction; pointer returns to 0.
        set_chan(0, MEMORY_READ, 32'h0BAD_0000, 32'h4, 32'h5, 32'h6);
        req_enable[0] = 1'b1;
        exp_ready_q.push_back(3'b001);
        wait_enable(c);
        memory_ready = 1'b1;
        tick;
        memory_ready = 1'b0;
        check("pre_reset_wait", 32'(dut.state), 32'(WAIT));
        reset = 1'b1;
        req_enable[0] = 1'b0;
        tick;
        reset = 1'b0;
        check_idle_outputs("midreset");
        tick;
        check("post_reset_valid", 32'(req_valid), 32'd0);
        set_chan(1, MEMORY_READ, 32'h300, 32'h0, 32'h0, 32'h0);
        set_chan(2, MEMORY_READ, 32'h400, 32'h0, 32'h0, 32'h0);
        req_enable[2:1] = 2'b11;
        expect_txn(1, 32'h1111_0001);
        expect_txn(2, 32'h2222_0002);
        wait_enable(c);
        check("post_reset_grant", read_memory_address, 32'h300);
        accept(32'h1111_0001, 1);
        req_enable[1] = 1'b0;
        wait_enable(c);
        check("post_reset_next", read_memory_address, 32'h400);
        accept(32'h2222_0002, 1);
        req_enable[2] = 1'b0;
        tick;

`ifdef MEMORY_ARBITER_TIMEOUT_EN
        set_chan(0, MEMORY_READ, 32'h500, 32'h0, 32'h0, 32'h0);
        set_chan(1, MEMORY_READ, 32'h600, 32'h0, 32'h0, 32'h0);
        req_enable[1:0] = 2'b11;
        expect_txn(0, 32'h0);
        expect_txn(1, 32'h3333_0003);
        wait_enable(c);
        read_memory_data = 32'hFFFF_FFFF;
        memory_ready = 1'b1;
        tick;
        memory_ready = 1'b0;
        repeat (7) tick;
        check("timeout_not_yet", 32'(req_valid), 32'd0);
        tick;
        check("timeout_valid", 32'(req_valid), 32'b001);
        check("timeout_error", 32'(req_error), 32'd1);
        req_enable[0] = 1'b0;
        wait_enable(c);
        check("timeout_next_grant", read_memory_address, 32'h600);
        accept(32'h3333_0003, 1);
        check("normal_error", 32'(req_error), 32'd0);
        req_enable[1] = 1'b0;
        tick;
`endif

        repeat (3) tick;
        check("ready_queue_empty", 32'(exp_ready_q.size()), 32'd0);
        check("valid_queue_empty", 32'(exp_valid_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
